udp_stream_dram_burst_writer: RTL and testbench

- Successor of the UDP-to-DRAM receive block in the exStickGE stream receive path.
- Sits between the UDP receive stream (r_* interface) and the DRAM write command/data FIFOs.
- Strips a parametrised header, takes the first payload word as a word-offset destination address, and streams the remaining payload as data words.
- New relative to the previous block: DRAM burst commands are issued on the fly while data streams (not after packet end); a byte strobe on the trailing partial word; clean abort of truncated packets; packet and error counters.

---
 rtl/udp_stream_dram_burst_writer.sv | 171 +++++++++++++++++
 tb/tb_udp_stream_dram_burst_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_stream_dram_burst_writer.sv
// UDP receive stream to DRAM writer: strips the header, uses the first payload word as a
// word-offset destination and issues burst commands while the payload streams through.
module udp_stream_dram_burst_writer #(
  parameter int ADDR_W     = 32,
  parameter int MAX_BURST  = 64,
  parameter int HDR_WORDS  = 4,
  parameter int LEN_WORD   = 3,
  parameter int ADDR_SHIFT = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                r_req,
  input  logic                r_enable,
  output logic                r_ack,
  input  logic [31:0]         r_data,
  output logic                w_req,
  output logic                w_enable,
  output logic [31:0]         w_data,
  output logic [35:0]         data_in,
  output logic                data_we,
  output logic [8+ADDR_W-1:0] ctrl_in,
  output logic                ctrl_we,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int KW = $clog2(MAX_BURST) + 1;
  localparam int IW = $clog2(HDR_WORDS) + 1;

  typedef enum logic [2:0] {IDLE, HDR, ADDR, DATA, WAIT_END} state_t;

  state_t            state;
  logic [31:0]       r_data_q;
  logic              r_en_q;
  logic [IW-1:0]     idx;
  logic [31:0]       len_q;
  logic [31:0]       n_q;
  logic [31:0]       cnt;
  logic [KW-1:0]     k;
  logic [ADDR_W-1:0] cur_addr;

  logic [1:0] rst_pipe;
  logic       rst_sync_n;
  logic       unused_ok;

  assign r_ack     = 1'b1;
  assign w_req     = 1'b0;
  assign w_enable  = 1'b0;
  assign w_data    = '0;
  assign unused_ok = r_req;

  // Assertion reaches the core immediately; release is retimed to clk by two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  logic [31:0]       words_total;
  logic [KW-1:0]     k_next;
  logic              last_word;
  logic              burst_full;
  logic [3:0]        tail_strb;
  logic [ADDR_W-1:0] byte_addr;

  always_comb begin
    words_total = (len_q + 32'd3) >> 2;
    k_next      = k + KW'(1);
    last_word   = (cnt + 32'd1) == n_q;
    burst_full  = k_next == KW'(MAX_BURST);
    byte_addr   = cur_addr << ADDR_SHIFT;
    case (len_q[1:0])
      2'd1:    tail_strb = 4'b0001;
      2'd2:    tail_strb = 4'b0011;
      2'd3:    tail_strb = 4'b0111;
      default: tail_strb = 4'b1111;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // NOTE: all state is updated with non-blocking assignments so every branch sees
  // the values from the start of the cycle, independent of statement order.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= IDLE;
      r_data_q <= '0;
      r_en_q   <= 1'b0;
      idx      <= '0;
      len_q    <= '0;
      n_q      <= '0;
      cnt      <= '0;
      k        <= '0;
      cur_addr <= '0;
      data_in  <= '0;
      data_we  <= 1'b0;
      ctrl_in  <= '0;
      ctrl_we  <= 1'b0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      r_data_q <= r_data;
      r_en_q   <= r_enable;
      data_we  <= 1'b0;
      ctrl_we  <= 1'b0;
      case (state)
        IDLE, HDR: begin
          if (r_en_q) begin
            if (idx == IW'(LEN_WORD)) len_q <= r_data_q;
            idx   <= idx + IW'(1);
            state <= (idx == IW'(HDR_WORDS - 1)) ? ADDR : HDR;
          end else begin
            if (state == HDR) err_cnt <= sat_inc(err_cnt);
            idx   <= '0;
            state <= IDLE;
          end
        end
        ADDR: begin
          idx <= '0;
          if (!r_en_q) begin
            err_cnt <= sat_inc(err_cnt);
            state   <= IDLE;
          end else begin
            cur_addr <= ADDR_W'(r_data_q);
            n_q      <= words_total - 32'd1;
            cnt      <= '0;
            k        <= '0;
            if (len_q <= 32'd4) begin
              err_cnt <= sat_inc(err_cnt);
              state   <= WAIT_END;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (r_en_q) begin
            data_we <= 1'b1;
            data_in <= {(last_word ? tail_strb : 4'b1111), r_data_q};
            cnt     <= cnt + 32'd1;
            k       <= k_next;
            if (last_word || burst_full) begin
              ctrl_we  <= 1'b1;
              ctrl_in  <= {8'(k_next), byte_addr};
              k        <= '0;
              cur_addr <= cur_addr + ADDR_W'(MAX_BURST);
            end
            if (last_word) begin
              pkt_cnt <= sat_inc(pkt_cnt);
              state   <= WAIT_END;
            end
          end else begin
            // Truncated packet: flush the partial burst so commands match written data.
            if (k != '0) begin
              ctrl_we <= 1'b1;
              ctrl_in <= {8'(k), byte_addr};
            end
            err_cnt <= sat_inc(err_cnt);
            state   <= IDLE;
          end
        end
        WAIT_END: if (!r_en_q) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_stream_dram_burst_writer.sv
// Directed bench for udp_stream_dram_burst_writer: sends packets, collects data and
// command writes from a negedge monitor, and checks them against hand-computed values.
module tb_udp_stream_dram_burst_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_req;
  logic        r_enable;
  logic        r_ack;
  logic [31:0] r_data;
  logic        w_req;
  logic        w_enable;
  logic [31:0] w_data;
  logic [35:0] data_in;
  logic        data_we;
  logic [39:0] ctrl_in;
  logic        ctrl_we;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [35:0] dq[$];
  logic [39:0] cq[$];
  int          cpos[$];

  always #5 clk = ~clk;

  udp_stream_dram_burst_writer dut (
    .clk(clk), .rst_n(rst_n), .r_req(r_req), .r_enable(r_enable), .r_ack(r_ack),
    .r_data(r_data), .w_req(w_req), .w_enable(w_enable), .w_data(w_data),
    .data_in(data_in), .data_we(data_we), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always @(negedge clk) begin
    if (data_we) dq.push_back(data_in);
    if (ctrl_we) begin
      cq.push_back(ctrl_in);
      cpos.push_back(dq.size());
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pay(input int j);
    return 32'hC0DE_0000 + 32'(j);
  endfunction

  task automatic drive(input logic [31:0] d);
    r_enable = 1'b1;
    r_data   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    r_enable = 1'b0;
    r_data   = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [31:0] len, input logic [31:0] base,
                          input int nd, input int extra);
    for (int i = 0; i < 4; i++) drive(i == 3 ? len : 32'hA000_0000 + 32'(i));
    drive(base);
    for (int j = 0; j < nd; j++) drive(pay(j));
    for (int j = 0; j < extra; j++) drive(32'hEEEE_0000 + 32'(j));
    r_enable = 1'b0;
    r_data   = '0;
  endtask

  task automatic clear_q();
    dq.delete();
    cq.delete();
    cpos.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    r_req    = 1'b0;
    r_enable = 1'b0;
    r_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    // Reset state
    check("rst_data_we", 64'(data_we), 64'd0);
    check("rst_ctrl_we", 64'(ctrl_we), 64'd0);
    check("rst_data_in", 64'(data_in), 64'd0);
    check("rst_ctrl_in", 64'(ctrl_in), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("r_ack_const", 64'(r_ack), 64'd1);
    check("w_side_zero", 64'({w_req, w_enable, w_data}), 64'd0);

    // Back-to-back: L=12 base 0x200 (2 words), one idle cycle, L=13 base 0x300 (3 words) + 3 surplus
    clear_q();
    send_pkt(32'd12, 32'h200, 2, 0);
    idle(1);
    send_pkt(32'd13, 32'h300, 3, 3);
    idle(4);
    check("b2b_ndata", 64'(dq.size()), 64'd5);
    check("b2b_nctrl", 64'(cq.size()), 64'd2);
    if (dq.size() == 5 && cq.size() == 2) begin
      check("b2b_a_d0", 64'(dq[0]), 64'({4'hF, pay(0)}));
      check("b2b_a_d1", 64'(dq[1]), 64'({4'hF, pay(1)}));
      check("b2b_b_d2", 64'(dq[4]), 64'({4'h1, pay(2)}));
      check("b2b_a_ctl", 64'(cq[0]), 64'({8'd2, 32'h800}));
      check("b2b_b_ctl", 64'(cq[1]), 64'({8'd3, 32'hC00}));
      check("b2b_b_pos", 64'(cpos[1]), 64'd5);
    end
    check("b2b_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // L=524 base 0x100: 130 words, bursts 64/64/2
    clear_q();
    send_pkt(32'd524, 32'h100, 130, 0);
    idle(4);
    check("big_ndata", 64'(dq.size()), 64'd130);
    check("big_nctrl", 64'(cq.size()), 64'd3);
    if (dq.size() == 130 && cq.size() == 3) begin
      check("big_ctl0", 64'(cq[0]), 64'({8'd64, 32'h400}));
      check("big_ctl1", 64'(cq[1]), 64'({8'd64, 32'h500}));
      check("big_ctl2", 64'(cq[2]), 64'({8'd2, 32'h600}));
      check("big_pos0", 64'(cpos[0]), 64'd64);
      check("big_pos1", 64'(cpos[1]), 64'd128);
      check("big_pos2", 64'(cpos[2]), 64'd130);
      check("big_d64", 64'(dq[64]), 64'({4'hF, pay(64)}));
      check("big_dlast", 64'(dq[129]), 64'({4'hF, pay(129)}));
    end
    check("big_pkt_cnt", 64'(pkt_cnt), 64'd3);

    // L=10 base 0x20: strobes 1111, 0011
    clear_q();
    send_pkt(32'd10, 32'h20, 2, 0);
    idle(4);
    check("l10_ndata", 64'(dq.size()), 64'd2);
    check("l10_nctrl", 64'(cq.size()), 64'd1);
    if (dq.size() == 2 && cq.size() == 1) begin
      check("l10_d0", 64'(dq[0]), 64'({4'hF, pay(0)}));
      check("l10_d1", 64'(dq[1]), 64'({4'h3, pay(1)}));
      check("l10_ctl", 64'(cq[0]), 64'({8'd2, 32'h80}));
    end

    // Runt L=4 with one surplus word
    clear_q();
    send_pkt(32'd4, 32'h40, 0, 1);
    idle(4);
    check("runt_ndata", 64'(dq.size()), 64'd0);
    check("runt_nctrl", 64'(cq.size()), 64'd0);
    check("runt_err", 64'(err_cnt), 64'd1);
    check("runt_pkt", 64'(pkt_cnt), 64'd4);

    // L=400 base 0x1000 truncated after 70 data words
    clear_q();
    send_pkt(32'd400, 32'h1000, 70, 0);
    idle(4);
    check("trunc_ndata", 64'(dq.size()), 64'd70);
    check("trunc_nctrl", 64'(cq.size()), 64'd2);
    if (cq.size() == 2) begin
      check("trunc_ctl0", 64'(cq[0]), 64'({8'd64, 32'h4000}));
      check("trunc_ctl1", 64'(cq[1]), 64'({8'd6, 32'h4100}));
      check("trunc_pos1", 64'(cpos[1]), 64'd70);
    end
    check("trunc_err", 64'(err_cnt), 64'd2);
    check("trunc_pkt", 64'(pkt_cnt), 64'd4);

    // Reset during data word 10 of L=100 base 0x50
    clear_q();
    send_pkt(32'd100, 32'h50, 9, 0);
    r_enable = 1'b1;
    r_data   = pay(9);
    rst_n    = 1'b0;
    #1;
    check("mid_rst_data_we", 64'(data_we), 64'd0);
    check("mid_rst_data_in", 64'(data_in), 64'd0);
    check("mid_rst_ctrl_we", 64'(ctrl_we), 64'd0);
    check("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
    check("mid_rst_err", 64'(err_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    check("mid_rst_nctrl", 64'(cq.size()), 64'd0);

    // Packet after reset: L=7 base 0x30, one word with strobe 0111
    clear_q();
    send_pkt(32'd7, 32'h30, 1, 0);
    idle(4);
    check("post_ndata", 64'(dq.size()), 64'd1);
    check("post_nctrl", 64'(cq.size()), 64'd1);
    if (dq.size() == 1 && cq.size() == 1) begin
      check("post_d0", 64'(dq[0]), 64'({4'h7, pay(0)}));
      check("post_ctl", 64'(cq[0]), 64'({8'd1, 32'hC0}));
    end
    check("post_pkt", 64'(pkt_cnt), 64'd1);
    check("post_err", 64'(err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
